pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Program-counter owner for the MIPS core; the consumer end of the branch-target adder path.
- Takes the PC+4 / branch-target pair produced in decode/execute and applies it with correct MIPS branch-delay-slot timing.
- Handles memory stalls, register/absolute jumps and the halt-on-jump-to-zero convention.
- Feeds the instruction-fetch address and pc_plus4 back to the branch-target adder and the link logic.

Parameters:
- RESET_VECTOR, 32'hBFC00000, PC value loaded on reset.
- HALT_ADDR, 32'h00000000, target address whose arrival ends execution.

Ports:
- clk  in  1  rising-edge clock (single clock domain)
- reset_n  in  1  asynchronous, active-low reset
- stall  in  1  fetch/memory wait; 1 freezes all state
- branch_taken  in  1  conditional branch resolved taken this cycle
- branch_target  in  32  output of branch-target adder (pc_plus4 + (imm<<2))
- jump  in  1  J/JAL/JR/JALR this cycle
- jump_target  in  32  absolute jump address
- pc  out  32  current fetch address
- pc_plus4  out  32  pc + 4 (combinational, wraps mod 2^32)
- in_delay_slot  out  1  instruction at pc is a delay-slot instruction
- active  out  1  CPU running; 0 once HALT_ADDR is reached

Behaviour:
- Reset (async, reset_n=0): pc=RESET_VECTOR, state=RUN, pending target=0, in_delay_slot=0, active=1. Release takes effect on the first clk edge with reset_n=1.
- States: RUN, DELAY, HALT. All register updates occur only on edges with stall=0; stall=1 holds every register and ignores branch_taken and jump.
- RUN:
  - No redirect: pc <= pc+4, stay in RUN.
  - jump=1: pending <= jump_target, pc <= pc+4, go to DELAY.
  - branch_taken=1 (and jump=0): pending <= branch_target, pc <= pc+4, go to DELAY.
  - jump and branch_taken both 1: jump wins.
- DELAY: in_delay_slot=1 (Moore, from state).
  - Next unstalled edge: pc <= pending.
  - If pending==HALT_ADDR: go to HALT; else go to RUN.
  - branch_taken/jump in DELAY (branch in delay slot) are ignored; the architecturally undefined case resolves to the first target.
- HALT: active=0, pc holds HALT_ADDR, all inputs ignored until reset.
- Redirect latency: the instruction after the branch (delay slot) is fetched next cycle; the target is fetched the cycle after that. That is 2 unstalled edges from the branch-decision edge.
- Arithmetic: pc+4 is 32-bit modulo; 32'hFFFFFFFC+4 = 0. Sequential wrap to 0 does NOT halt; only a redirect target equal to HALT_ADDR halts.
- A stall during DELAY keeps in_delay_slot=1 and pending intact.
- Reset asserted mid-DELAY discards pending immediately.

Optional Feature:
- Macro: PC_SEQ_ALIGN_CHECK_EN.
- Defined:
  - Adds output addr_error (1 bit), reset 0.
  - A taken redirect whose target[1:0]!=0 sets addr_error (sticky until reset) and forces HALT instead of DELAY. pc is not updated.
- Undefined: no port; target[1:0] are passed through unchecked.

Decomposition:
- Package pc_seq_pkg: state enum (RUN, DELAY, HALT), RESET_VECTOR and HALT_ADDR defaults, 32-bit word typedef.
- No sub-module is natural. A single always_ff holds the state, pc and pending registers; combinational logic gives pc_plus4, next-pc select, in_delay_slot and active.

Test Plan:
- Reset, then 3 unstalled cycles -> pc 32'hBFC00000, BFC00004, BFC00008, BFC0000C; active=1, in_delay_slot=0.
- At pc=BFC00010, branch_taken=1, branch_target=BFC00100 -> next pc BFC00014 with in_delay_slot=1, then pc BFC00100 with in_delay_slot=0.
- jump=1 with jump_target=0 -> delay slot executes at pc+4, then pc=0, active=0; further jumps/branches leave pc=0.
- jump=1 (target BFC00200) and branch_taken=1 (target BFC00300) simultaneously -> pc reaches BFC00200. A branch asserted during the delay slot is ignored.
- Stall held 4 cycles inside DELAY -> pc and in_delay_slot frozen; after release, the first edge loads the target. reset_n pulsed low mid-DELAY -> pc=BFC00000 immediately, in_delay_slot=0.
- With PC_SEQ_ALIGN_CHECK_EN: branch_target=BFC00102 -> addr_error=1, active=0, pc unchanged and held.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and defaults for the MIPS program-counter sequencer.
// Optional build macro used by pc_sequencer: PC_SEQ_ALIGN_CHECK_EN.
package pc_seq_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DELAY = 2'd1,
    ST_HALT  = 2'd2
  } state_e;

  localparam word_t RESET_VECTOR_DEF = 32'hBFC0_0000;
  localparam word_t HALT_ADDR_DEF    = 32'h0000_0000;

  function automatic logic is_word_aligned(input word_t addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/pc_sequencer.sv
// Program-counter owner: applies branch/jump targets with one delay slot, stalls, halts on HALT_ADDR.
// Build macro PC_SEQ_ALIGN_CHECK_EN adds addr_error and halts on a misaligned redirect target.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter word_t RESET_VECTOR = RESET_VECTOR_DEF,
  parameter word_t HALT_ADDR    = HALT_ADDR_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        in_delay_slot,
  output logic        active
`ifdef PC_SEQ_ALIGN_CHECK_EN
  ,
  output logic        addr_error
`endif
);

  state_e state_q, state_d;
  word_t  pc_q, pc_d;
  word_t  pending_q, pending_d;
  word_t  redirect_target;
  logic   redirect;
`ifdef PC_SEQ_ALIGN_CHECK_EN
  logic   addr_error_q, addr_error_d;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_RUN;
      pc_q      <= RESET_VECTOR;
      pending_q <= '0;
`ifdef PC_SEQ_ALIGN_CHECK_EN
      addr_error_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pending_q <= pending_d;
`ifdef PC_SEQ_ALIGN_CHECK_EN
      addr_error_q <= addr_error_d;
`endif
    end
  end

  // A jump outranks a simultaneous taken branch.
  assign redirect        = jump | branch_taken;
  assign redirect_target = jump ? jump_target : branch_target;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pending_d = pending_q;
`ifdef PC_SEQ_ALIGN_CHECK_EN
    addr_error_d = addr_error_q;
`endif
    if (!stall) begin
      case (state_q)
        ST_RUN: begin
          if (redirect) begin
`ifdef PC_SEQ_ALIGN_CHECK_EN
            if (!is_word_aligned(redirect_target)) begin
              addr_error_d = 1'b1;
              state_d      = ST_HALT;
            end else begin
              pending_d = redirect_target;
              pc_d      = pc_plus4;
              state_d   = ST_DELAY;
            end
`else
            pending_d = redirect_target;
            pc_d      = pc_plus4;
            state_d   = ST_DELAY;
`endif
          end else begin
            pc_d = pc_plus4;
          end
        end
        // Redirects seen in the delay slot are dropped; the first target wins.
        ST_DELAY: begin
          pc_d    = pending_q;
          state_d = (pending_q == HALT_ADDR) ? ST_HALT : ST_RUN;
        end
        default: begin
        end
      endcase
    end
  end

  assign pc            = pc_q;
  assign pc_plus4      = pc_q + 32'd4;
  assign in_delay_slot = (state_q == ST_DELAY);
  assign active        = (state_q != ST_HALT);
`ifdef PC_SEQ_ALIGN_CHECK_EN
  assign addr_error    = addr_error_q;
`endif

endmodule
